wb_port_arbiter: RTL and testbench

Arbitrates the single register-file write port between the in-order pipeline writeback stage and the out-of-band multi-cycle unit (mul/div) result path. Multi-cycle results wait in a 2-entry buffer while the writeback stage wins by default, and a bounded-wait guard stalls writeback when a buffered result has waited too long. The block sits between the writeback stage output, the mul/div unit and the register file. It also exports a pending-destination mask so the hazard unit can interlock reads of registers whose results are still buffered.

---
 rtl/wb_port_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_wb_port_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// wb_port_arbiter
//
// Shares the single register-file write port between the in-order writeback
// stage and the out-of-band mul/div result path. Mul/div results are parked
// in a 2-entry FIFO. Writeback wins by default, and the FIFO drains in idle
// cycles. When WB_STARVE_GUARD_EN is defined, a wait counter tracks how long
// the FIFO head has been losing. Once it reaches MAX_WAIT, the head is forced
// through and writeback is stalled for that cycle.
//
// Configuration macro:
//   WB_STARVE_GUARD_EN  defined   -> bounded-wait guard active
//                       undefined -> writeback always wins, w_stall == 0
//
// Parameters:
//   XLEN      data width
//   MAX_WAIT  losing cycles tolerated before the guard fires (1..15)
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   w_valid/w_wen       writeback stage holds a valid, register-writing instr
//   w_dst/w_data        writeback destination and result
//   w_stall      (out)  writeback must hold its instruction (combinational)
//   md_valid     (in)   mul/div result offered
//   md_ready     (out)  FIFO can accept a result (from current count only)
//   md_dst/md_data      mul/div destination and result
//   rf_wen/rf_wa/rf_wd  registered register-file write port
//   pend_mask    (out)  registered; bit i set while a buffered entry targets xi
//   busy         (out)  registered; FIFO is non-empty
// -----------------------------------------------------------------------------
module wb_port_arbiter #(
  parameter int XLEN     = 64,
  parameter int MAX_WAIT = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            w_valid,
  input  logic            w_wen,
  input  logic [4:0]      w_dst,
  input  logic [XLEN-1:0] w_data,
  output logic            w_stall,
  input  logic            md_valid,
  output logic            md_ready,
  input  logic [4:0]      md_dst,
  input  logic [XLEN-1:0] md_data,
  output logic            rf_wen,
  output logic [4:0]      rf_wa,
  output logic [XLEN-1:0] rf_wd,
  output logic [31:0]     pend_mask,
  output logic            busy
);

  if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_bad_max_wait
    $error("wb_port_arbiter: MAX_WAIT must be in 1..15");
  end

  // FIFO state
  logic [1:0]      r_count;
  logic            r_wr_ptr;
  logic            r_rd_ptr;
  logic [4:0]      r_fifo_dst  [2];
  logic [XLEN-1:0] r_fifo_data [2];

  // Arbitration and next-state wires
  logic            w_req;
  logic            w_empty;
  logic            w_enq;
  logic            w_force;
  logic            w_grant_fifo;
  logic            w_grant_wb;
  logic [1:0]      w_count_n;
  logic            w_wr_ptr_n;
  logic            w_rd_ptr_n;
  logic [4:0]      w_dst_n  [2];
  logic [1:0]      w_slot_vld_n;
  logic [31:0]     w_mask_n;

  // A write to x0 is architecturally a no-op, so it never competes for the port.
  assign w_req    = w_valid && w_wen && (w_dst != 5'd0);
  assign w_empty  = (r_count == 2'd0);
  assign md_ready = (r_count != 2'd2);
  // A result for x0 completes its handshake but is dropped instead of stored.
  assign w_enq    = md_valid && md_ready && (md_dst != 5'd0);

`ifdef WB_STARVE_GUARD_EN
  logic [3:0] r_wait;
  logic [3:0] w_wait_n;
  logic       r_force;

  assign w_force = r_force;

  // The counter only measures the current head's losing streak; any head
  // grant or an empty FIFO restarts it.
  always_comb begin
    w_wait_n = r_wait;
    if (w_empty || w_grant_fifo) begin
      w_wait_n = 4'd0;
    end else if (r_wait != 4'hF) begin
      w_wait_n = r_wait + 4'd1;
    end
  end

  // force is registered so w_stall never depends on this cycle's md inputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wait  <= 4'd0;
      r_force <= 1'b0;
    end else begin
      r_wait  <= w_wait_n;
      r_force <= (w_wait_n >= 4'(MAX_WAIT));
    end
  end
`else
  assign w_force = 1'b0;
`endif

  // Forced head first, then writeback, then opportunistic drain.
  always_comb begin
    w_grant_fifo = 1'b0;
    w_grant_wb   = 1'b0;
    if (w_force && !w_empty) begin
      w_grant_fifo = 1'b1;
    end else if (w_req) begin
      w_grant_wb   = 1'b1;
    end else if (!w_empty) begin
      w_grant_fifo = 1'b1;
    end
  end

  assign w_stall = w_force && w_req;

  always_comb begin
    w_count_n = r_count;
    case ({w_enq, w_grant_fifo})
      2'b10:   w_count_n = r_count + 2'd1;
      2'b01:   w_count_n = r_count - 2'd1;
      default: w_count_n = r_count;
    endcase
  end

  assign w_wr_ptr_n = r_wr_ptr ^ w_enq;
  assign w_rd_ptr_n = r_rd_ptr ^ w_grant_fifo;

  // pend_mask reflects the FIFO as it will be after this edge, so a granted
  // entry drops out of the mask the same cycle its write shows on rf_wen.
  always_comb begin
    w_mask_n     = 32'd0;
    w_slot_vld_n = 2'b00;
    for (int i = 0; i < 2; i++) begin
      w_dst_n[i] = (w_enq && (r_wr_ptr == i[0])) ? md_dst : r_fifo_dst[i];
      if (w_count_n == 2'd2) begin
        w_slot_vld_n[i] = 1'b1;
      end else if (w_count_n == 2'd1) begin
        w_slot_vld_n[i] = (w_rd_ptr_n == i[0]);
      end
      if (w_slot_vld_n[i]) begin
        w_mask_n[w_dst_n[i]] = 1'b1;
      end
    end
  end

  // Control and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count   <= 2'd0;
      r_wr_ptr  <= 1'b0;
      r_rd_ptr  <= 1'b0;
      rf_wen    <= 1'b0;
      rf_wa     <= 5'd0;
      rf_wd     <= '0;
      pend_mask <= 32'd0;
      busy      <= 1'b0;
    end else begin
      r_count   <= w_count_n;
      r_wr_ptr  <= w_wr_ptr_n;
      r_rd_ptr  <= w_rd_ptr_n;
      pend_mask <= w_mask_n;
      busy      <= (w_count_n != 2'd0);
      rf_wen    <= w_grant_fifo || w_grant_wb;
      if (w_grant_fifo) begin
        rf_wa <= r_fifo_dst[r_rd_ptr];
        rf_wd <= r_fifo_data[r_rd_ptr];
      end else if (w_grant_wb) begin
        rf_wa <= w_dst;
        rf_wd <= w_data;
      end
    end
  end

  // FIFO storage; slot contents are only meaningful under r_count.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_fifo_dst[r_wr_ptr]  <= md_dst;
      r_fifo_data[r_wr_ptr] <= md_data;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        w_valid, w_wen;
  logic [4:0]  w_dst;
  logic [63:0] w_data;
  logic        w_stall;
  logic        md_valid;
  logic        md_ready;
  logic [4:0]  md_dst;
  logic [63:0] md_data;
  logic        rf_wen;
  logic [4:0]  rf_wa;
  logic [63:0] rf_wd;
  logic [31:0] pend_mask;
  logic        busy;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  wb_port_arbiter #(.XLEN(64), .MAX_WAIT(4)) dut (
    .clk(clk), .reset(reset),
    .w_valid(w_valid), .w_wen(w_wen), .w_dst(w_dst), .w_data(w_data),
    .w_stall(w_stall),
    .md_valid(md_valid), .md_ready(md_ready), .md_dst(md_dst), .md_data(md_data),
    .rf_wen(rf_wen), .rf_wa(rf_wa), .rf_wd(rf_wd),
    .pend_mask(pend_mask), .busy(busy)
  );

  typedef struct {
    logic        wv;
    logic        wen;
    logic [4:0]  wdst;
    logic [63:0] wdata;
    logic        mv;
    logic [4:0]  mdst;
    logic [63:0] mdata;
    logic        e_ready;
    logic        e_stall;
    logic        e_wen;
    logic [4:0]  e_wa;
    logic [63:0] e_wd;
    logic [31:0] e_pend;
    logic        e_busy;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

  function automatic vec_t mk(
    input logic wv, input logic wen, input logic [4:0] wdst, input logic [63:0] wdata,
    input logic mv, input logic [4:0] mdst, input logic [63:0] mdata,
    input logic e_ready, input logic e_stall, input logic e_wen,
    input logic [4:0] e_wa, input logic [63:0] e_wd, input logic [31:0] e_pend,
    input logic e_busy);
    vec_t v;
    v.wv = wv; v.wen = wen; v.wdst = wdst; v.wdata = wdata;
    v.mv = mv; v.mdst = mdst; v.mdata = mdata;
    v.e_ready = e_ready; v.e_stall = e_stall; v.e_wen = e_wen;
    v.e_wa = e_wa; v.e_wd = e_wd; v.e_pend = e_pend; v.e_busy = e_busy;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic wv, input logic wen, input logic [4:0] wdst,
                       input logic [63:0] wdata, input logic mv, input logic [4:0] mdst,
                       input logic [63:0] mdata);
    w_valid = wv; w_wen = wen; w_dst = wdst; w_data = wdata;
    md_valid = mv; md_dst = mdst; md_data = mdata;
  endtask

  // Drive on the falling edge, check combinational outputs before the rising
  // edge, then registered outputs 1ns after it.
  task automatic step_chk_pre(input string nm, input logic e_ready, input logic e_stall);
    #2;
    chk({nm, ".md_ready"}, 64'(md_ready), 64'(e_ready));
    chk({nm, ".w_stall"},  64'(w_stall),  64'(e_stall));
    @(posedge clk);
    #1;
  endtask

  task automatic chk_post(input string nm, input logic e_wen, input logic [4:0] e_wa,
                          input logic [63:0] e_wd, input logic [31:0] e_pend,
                          input logic e_busy);
    chk({nm, ".rf_wen"},    64'(rf_wen),    64'(e_wen));
    chk({nm, ".rf_wa"},     64'(rf_wa),     64'(e_wa));
    chk({nm, ".rf_wd"},     rf_wd,          e_wd);
    chk({nm, ".pend_mask"}, 64'(pend_mask), 64'(e_pend));
    chk({nm, ".busy"},      64'(busy),      64'(e_busy));
  endtask

  initial begin
    //            wv wen wdst wdata   mv mdst mdata     rdy stl wen wa  wd        pend          busy
    vecs[0]  = mk(0, 0,  0,   0,      1, 5,   'h1234,   1,  0,  0,  9,  'h99,     32'h20,       1);
    vecs[1]  = mk(0, 0,  0,   0,      0, 0,   0,        1,  0,  1,  5,  'h1234,   32'h0,        0);
    vecs[2]  = mk(1, 1,  10,  'hA0,   1, 3,   'h33,     1,  0,  1,  10, 'hA0,     32'h8,        1);
    vecs[3]  = mk(1, 1,  11,  'hB0,   1, 7,   'h77,     1,  0,  1,  11, 'hB0,     32'h88,       1);
    vecs[4]  = mk(1, 1,  12,  'hC0,   1, 20,  'h2020,   0,  0,  1,  12, 'hC0,     32'h88,       1);
    vecs[5]  = mk(1, 1,  13,  'hD0,   1, 20,  'h2020,   0,  0,  1,  13, 'hD0,     32'h88,       1);
    vecs[6]  = mk(0, 1,  13,  'hD0,   1, 20,  'h2020,   0,  0,  1,  3,  'h33,     32'h80,       1);
    vecs[7]  = mk(0, 1,  13,  'hD0,   1, 20,  'h2020,   1,  0,  1,  7,  'h77,     32'h00100000, 1);
    vecs[8]  = mk(0, 0,  0,   0,      0, 0,   0,        1,  0,  1,  20, 'h2020,   32'h0,        0);
    vecs[9]  = mk(1, 1,  0,   'hEE,   1, 0,   'hFF,     1,  0,  0,  20, 'h2020,   32'h0,        0);
    vecs[10] = mk(1, 0,  4,   'h44,   0, 0,   0,        1,  0,  0,  20, 'h2020,   32'h0,        0);
    vecs[11] = mk(0, 1,  4,   'h44,   0, 0,   0,        1,  0,  0,  20, 'h2020,   32'h0,        0);
    vecs[12] = mk(1, 1,  31,  64'hFFFF_0000_0000_0001, 0, 0, 0,
                                                        1,  0,  1,  31, 64'hFFFF_0000_0000_0001, 32'h0, 0);

    // Reset with both sources requesting.
    reset = 1'b1;
    drive(1, 1, 1, 'hAA, 1, 9, 'h99);
    repeat (2) @(posedge clk);
    #1;
    chk("rst.rf_wen",    64'(rf_wen), 64'(0));
    chk("rst.pend_mask", 64'(pend_mask), 64'(0));
    chk("rst.w_stall",   64'(w_stall), 64'(0));
    chk("rst.md_ready",  64'(md_ready), 64'(1));
    chk("rst.busy",      64'(busy), 64'(0));
    chk("rst.rf_wa",     64'(rf_wa), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    step_chk_pre("rel", 1, 0);
    chk_post("rel", 1, 1, 'hAA, 32'h200, 1);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    step_chk_pre("rel2", 1, 0);
    chk_post("rel2", 1, 9, 'h99, 32'h0, 0);

    // Table of single-cycle vectors.
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i].wv, vecs[i].wen, vecs[i].wdst, vecs[i].wdata,
            vecs[i].mv, vecs[i].mdst, vecs[i].mdata);
      step_chk_pre($sformatf("v%0d", i), vecs[i].e_ready, vecs[i].e_stall);
      chk_post($sformatf("v%0d", i), vecs[i].e_wen, vecs[i].e_wa, vecs[i].e_wd,
               vecs[i].e_pend, vecs[i].e_busy);
    end

`ifdef WB_STARVE_GUARD_EN
    // Starvation with the guard: head 3 forced after 4 losing cycles, then 7.
    @(negedge clk);
    drive(1, 1, 10, 'hA0, 1, 3, 'h33);
    step_chk_pre("g.a", 1, 0);
    chk_post("g.a", 1, 10, 'hA0, 32'h8, 1);
    @(negedge clk);
    drive(1, 1, 10, 'hA0, 1, 7, 'h77);
    step_chk_pre("g.b", 1, 0);
    chk_post("g.b", 1, 10, 'hA0, 32'h88, 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(1, 1, 10, 'hA0, 0, 0, 0);
      step_chk_pre($sformatf("g.l%0d", k), 0, 0);
      chk_post($sformatf("g.l%0d", k), 1, 10, 'hA0, 32'h88, 1);
    end
    @(negedge clk);
    step_chk_pre("g.f3", 0, 1);
    chk_post("g.f3", 1, 3, 'h33, 32'h80, 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      step_chk_pre($sformatf("g.m%0d", k), 1, 0);
      chk_post($sformatf("g.m%0d", k), 1, 10, 'hA0, 32'h80, 1);
    end
    @(negedge clk);
    step_chk_pre("g.f7", 1, 1);
    chk_post("g.f7", 1, 7, 'h77, 32'h0, 0);
    @(negedge clk);
    step_chk_pre("g.after", 1, 0);
    chk_post("g.after", 1, 10, 'hA0, 32'h0, 0);
`else
    // Without the guard, writeback keeps winning however long the head waits.
    @(negedge clk);
    drive(1, 1, 10, 'hA0, 1, 3, 'h33);
    step_chk_pre("ng.a", 1, 0);
    chk_post("ng.a", 1, 10, 'hA0, 32'h8, 1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      drive(1, 1, 5'(14 + k), 64'(k), 0, 0, 0);
      step_chk_pre($sformatf("ng.l%0d", k), 1, 0);
      chk_post($sformatf("ng.l%0d", k), 1, 5'(14 + k), 64'(k), 32'h8, 1);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    step_chk_pre("ng.drain", 1, 0);
    chk_post("ng.drain", 1, 3, 'h33, 32'h0, 0);
`endif

    // Reset mid-operation drops the buffered entry without writing it.
    @(negedge clk);
    drive(0, 0, 0, 0, 1, 6, 'h66);
    step_chk_pre("mr.enq", 1, 0);
    chk("mr.enq.pend", 64'(pend_mask), 64'h40);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    #1;
    chk("mr.busy",  64'(busy), 64'(0));
    chk("mr.pend",  64'(pend_mask), 64'(0));
    chk("mr.rf_wa", 64'(rf_wa), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    step_chk_pre("mr.idle", 1, 0);
    chk_post("mr.idle", 0, 0, 0, 32'h0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
